// File: rtl/uart_tx_serializer_if.sv
// Handshake, configuration and line signals between the TX holding path and the serializer.
// Latency: none, wiring only.
// Backpressure: START is a level request and ACK confirms each accepted character.
interface uart_tx_serializer_if;
   logic       CLEAR;
   logic       BAUDCE;
   logic [1:0] WLS;
   logic       STB;
   logic       PEN;
   logic       EPS;
   logic       SP;
   logic       BC;
   logic [7:0] DIN;
   logic       START;
   logic       ACK;
   logic       BUSY;
   logic       DONE;
   logic       TXD;

   // The master side is the register and FIFO logic that feeds characters in.
   modport master (
      output CLEAR, BAUDCE, WLS, STB, PEN, EPS, SP, BC, DIN, START,
      input  ACK, BUSY, DONE, TXD
   );

   // The slave side is the serializer itself.
   modport slave (
      input  CLEAR, BAUDCE, WLS, STB, PEN, EPS, SP, BC, DIN, START,
      output ACK, BUSY, DONE, TXD
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
// Latency: TXD shows the start bit in the cycle after START is accepted; each bit lasts 16 BAUDCE pulses.
// Backpressure: START is sampled only in IDLE, so a held START waits until the current frame ends.
module uart_tx_serializer (
   input  logic                  CLK,
   input  logic                  RST,
   uart_tx_serializer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STARTBIT,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] dat_q, dat_d;
   logic [1:0] wls_q, wls_d;
   logic       stb_q, stb_d;
   logic       pen_q, pen_d;
   logic       eps_q, eps_d;
   logic       sp_q, sp_d;
   logic       txd_q, txd_d;
   logic       ack_q, ack_d;
   logic       done_q, done_d;

   logic [2:0] last_idx;
   logic       par_x;
   logic       par_bit;
   logic       bit_end;
   logic       stop2_end;
   logic       line_d;

   // Parity over only the data bits actually sent, then mapped by the stick/even selects.
   always_comb begin
      last_idx = {1'b0, wls_q} + 3'd4;
      par_x    = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i <= int'(last_idx)) begin
            par_x = par_x ^ dat_q[i];
         end
      end
      par_bit = sp_q ? ~eps_q : (eps_q ? par_x : ~par_x);
   end

   // Frame sequencing: acceptance, tick counting, bit index and state advance.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      idx_d     = idx_q;
      dat_d     = dat_q;
      wls_d     = wls_q;
      stb_d     = stb_q;
      pen_d     = pen_q;
      eps_d     = eps_q;
      sp_d      = sp_q;
      ack_d     = 1'b0;
      done_d    = 1'b0;
      bit_end   = bus.BAUDCE && (tick_q == 4'd15);
      stop2_end = bus.BAUDCE && (tick_q == ((wls_q == 2'b00) ? 4'd7 : 4'd15));

      if (bus.CLEAR) begin
         state_d = S_IDLE;
         tick_d  = 4'd0;
         idx_d   = 3'd0;
      end else if (state_q == S_IDLE) begin
         if (bus.START) begin
            dat_d   = bus.DIN;
            wls_d   = bus.WLS;
            stb_d   = bus.STB;
            pen_d   = bus.PEN;
            eps_d   = bus.EPS;
            sp_d    = bus.SP;
            tick_d  = 4'd0;
            idx_d   = 3'd0;
            ack_d   = 1'b1;
            state_d = S_STARTBIT;
         end
      end else begin
         if (bus.BAUDCE) begin
            tick_d = tick_q + 4'd1;
         end
         case (state_q)
            S_STARTBIT: if (bit_end) state_d = S_DATA;
            S_DATA: begin
               if (bit_end) begin
                  if (idx_q == last_idx) begin
                     state_d = pen_q ? S_PARITY : S_STOP1;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
            S_PARITY:   if (bit_end) state_d = S_STOP1;
            S_STOP1: begin
               if (bit_end) begin
                  if (stb_q) begin
                     state_d = S_STOP2;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            S_STOP2: begin
               if (stop2_end) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // Line level for the upcoming state; break overrides it without touching the FSM.
   always_comb begin
      case (state_d)
         S_STARTBIT: line_d = 1'b0;
         S_DATA:     line_d = dat_d[idx_d];
         S_PARITY:   line_d = par_bit;
         default:    line_d = 1'b1;
      endcase
      txd_d = line_d & ~bus.BC;
   end

   // State and output registers; reset leaves the line idle-high.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         tick_q  <= 4'd0;
         idx_q   <= 3'd0;
         dat_q   <= 8'd0;
         wls_q   <= 2'd0;
         stb_q   <= 1'b0;
         pen_q   <= 1'b0;
         eps_q   <= 1'b0;
         sp_q    <= 1'b0;
         txd_q   <= 1'b1;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         dat_q   <= dat_d;
         wls_q   <= wls_d;
         stb_q   <= stb_d;
         pen_q   <= pen_d;
         eps_q   <= eps_d;
         sp_q    <= sp_d;
         txd_q   <= txd_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign bus.TXD  = txd_q;
   assign bus.ACK  = ack_q;
   assign bus.DONE = done_q;
   assign bus.BUSY = (state_q != S_IDLE);

endmodule
